wb_exc_commit: RTL and testbench

- Writeback stage of the 5-stage MIPS core. Latches MEM-stage results, prioritises per-instruction exception flags and samples pending interrupts.
- Drives the CP0 register file's commit interface: mtc0 write, exception record, eret, read address.
- Commits GPR writes, issues the pipeline flush and redirect target.
- Holds retire and exception performance counters.

---
 rtl/wb_exc_commit_pkg.sv | 49 ++++
 rtl/wb_exc_commit_exc_prio.sv | 49 ++++
 rtl/wb_exc_commit.sv | 150 +++++++++++++++
 tb/tb_wb_exc_commit.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_exc_commit_pkg.sv
// Shared WB/CP0 definitions: exception codes, CP0 addresses,
// default exception vector and the MEM->WB bundle.
package wb_exc_commit_pkg;

  localparam logic [4:0] EX_INT  = 5'h00;
  localparam logic [4:0] EX_ADEL = 5'h04;
  localparam logic [4:0] EX_ADES = 5'h05;
  localparam logic [4:0] EX_SYS  = 5'h08;
  localparam logic [4:0] EX_BP   = 5'h09;
  localparam logic [4:0] EX_RI   = 5'h0a;
  localparam logic [4:0] EX_OV   = 5'h0c;

  localparam logic [7:0] CR_BADVADDR = {5'd8, 3'd0};
  localparam logic [7:0] CR_COUNT    = {5'd9, 3'd0};
  localparam logic [7:0] CR_COMPARE  = {5'd11, 3'd0};
  localparam logic [7:0] CR_STATUS   = {5'd12, 3'd0};
  localparam logic [7:0] CR_CAUSE    = {5'd13, 3'd0};
  localparam logic [7:0] CR_EPC      = {5'd14, 3'd0};

  localparam logic [31:0] EX_ENTRY_DEF = 32'hbfc00380;
  localparam int          EXCNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    BV_NONE,
    BV_PC,
    BV_DATA
  } bv_sel_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        bd;
    logic        if_adel;
    logic        ri;
    logic        sys;
    logic        bp;
    logic        ov;
    logic        adel;
    logic        ades;
    logic [31:0] badvaddr;
    logic        eret;
    logic        mtc0;
    logic        mfc0;
    logic [7:0]  c0_addr;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
  } ms_ws_t;

endpackage

// File: rtl/wb_exc_commit_exc_prio.sv
// Exception priority encoder for the WB instruction:
// first matching source wins; interrupt outranks everything.
module wb_exc_commit_exc_prio
  import wb_exc_commit_pkg::*;
(
  input  logic       valid,
  input  logic       has_int,
  input  logic       if_adel,
  input  logic       ri,
  input  logic       ov,
  input  logic       sys,
  input  logic       bp,
  input  logic       adel,
  input  logic       ades,
  output logic       any,
  output logic [4:0] excode,
  output bv_sel_t    badvaddr_sel
);

  always_comb begin
    any          = 1'b0;
    excode       = EX_INT;
    badvaddr_sel = BV_NONE;
    if (valid) begin
      any = 1'b1;
      priority case (1'b1)
        has_int: excode = EX_INT;
        if_adel: begin
          excode       = EX_ADEL;
          badvaddr_sel = BV_PC;
        end
        ri:      excode = EX_RI;
        ov:      excode = EX_OV;
        sys:     excode = EX_SYS;
        bp:      excode = EX_BP;
        adel: begin
          excode       = EX_ADEL;
          badvaddr_sel = BV_DATA;
        end
        ades: begin
          excode       = EX_ADES;
          badvaddr_sel = BV_DATA;
        end
        default: any = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/wb_exc_commit.sv
// Writeback stage: commits GPR/CP0 side effects, raises
// exceptions and eret, drives flush/redirect, counts retires.
module wb_exc_commit
  import wb_exc_commit_pkg::*;
#(
  parameter logic [31:0] EX_ENTRY = EX_ENTRY_DEF,
  parameter int          EXCNT_W  = EXCNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ms_to_ws_valid,
  output logic               ws_allowin,
  input  logic [31:0]        ms_pc,
  input  logic               ms_bd,
  input  logic               ms_ex_if_adel,
  input  logic               ms_ex_ri,
  input  logic               ms_ex_sys,
  input  logic               ms_ex_bp,
  input  logic               ms_ex_ov,
  input  logic               ms_ex_adel,
  input  logic               ms_ex_ades,
  input  logic [31:0]        ms_badvaddr,
  input  logic               ms_eret,
  input  logic               ms_mtc0,
  input  logic               ms_mfc0,
  input  logic [7:0]         ms_c0_addr,
  input  logic               ms_gr_we,
  input  logic [4:0]         ms_dest,
  input  logic [31:0]        ms_result,
  input  logic [31:0]        c0_rdata,
  input  logic [31:0]        c0_epc,
  input  logic               has_int,
  output logic               mtc0_we,
  output logic [7:0]         c0_raddr,
  output logic [31:0]        c0_wdata,
  output logic               wb_ex,
  output logic [4:0]         wb_excode,
  output logic               wb_bd,
  output logic [31:0]        wb_pc,
  output logic [31:0]        wb_badvaddr,
  output logic               eret_flush,
  output logic               rf_we,
  output logic [4:0]         rf_waddr,
  output logic [31:0]        rf_wdata,
  output logic               flush,
  output logic [31:0]        flush_target,
  output logic [31:0]        retire_cnt,
  output logic [EXCNT_W-1:0] ex_cnt
);

  logic    ws_valid;
  logic    ws_ready_go;
  ms_ws_t  ms;
  ms_ws_t  ws;
  bv_sel_t bv_sel;

  assign ms = '{
    pc:       ms_pc,
    bd:       ms_bd,
    if_adel:  ms_ex_if_adel,
    ri:       ms_ex_ri,
    sys:      ms_ex_sys,
    bp:       ms_ex_bp,
    ov:       ms_ex_ov,
    adel:     ms_ex_adel,
    ades:     ms_ex_ades,
    badvaddr: ms_badvaddr,
    eret:     ms_eret,
    mtc0:     ms_mtc0,
    mfc0:     ms_mfc0,
    c0_addr:  ms_c0_addr,
    gr_we:    ms_gr_we,
    dest:     ms_dest,
    result:   ms_result
  };

  assign ws_ready_go = 1'b1;
  assign ws_allowin  = !ws_valid || ws_ready_go;

  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid <= 1'b0;
    end else if (flush) begin
      ws_valid <= 1'b0;
    end else if (ws_allowin) begin
      ws_valid <= ms_to_ws_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ws <= '0;
    end else if (ws_allowin && ms_to_ws_valid && !flush) begin
      ws <= ms;
    end
  end

  wb_exc_commit_exc_prio u_exc_prio (
    .valid        (ws_valid),
    .has_int      (has_int),
    .if_adel      (ws.if_adel),
    .ri           (ws.ri),
    .ov           (ws.ov),
    .sys          (ws.sys),
    .bp           (ws.bp),
    .adel         (ws.adel),
    .ades         (ws.ades),
    .any          (wb_ex),
    .excode       (wb_excode),
    .badvaddr_sel (bv_sel)
  );

  always_comb begin
    wb_badvaddr = 32'h0;
    unique case (bv_sel)
      BV_PC:   wb_badvaddr = ws.pc;
      BV_DATA: wb_badvaddr = ws.badvaddr;
      default: wb_badvaddr = 32'h0;
    endcase
  end

  assign wb_pc      = ws.pc;
  assign wb_bd      = ws.bd;
  assign eret_flush = ws_valid && ws.eret && !wb_ex;
  assign mtc0_we    = ws_valid && ws.mtc0 && !wb_ex;
  assign c0_raddr   = ws.c0_addr;
  assign c0_wdata   = ws.result;
  assign rf_we      = ws_valid && ws.gr_we && !wb_ex;
  assign rf_waddr   = ws.dest;
  assign rf_wdata   = ws.mfc0 ? c0_rdata : ws.result;

  // EPC is read before the edge at which CP0 overwrites it
  assign flush        = wb_ex || eret_flush;
  assign flush_target = eret_flush ? c0_epc : EX_ENTRY;

  always_ff @(posedge clk) begin
    if (reset) begin
      retire_cnt <= 32'h0;
      ex_cnt     <= '0;
    end else begin
      if (ws_valid && !wb_ex) begin
        retire_cnt <= retire_cnt + 32'd1;
      end
      if (wb_ex && (ex_cnt != {EXCNT_W{1'b1}})) begin
        ex_cnt <= ex_cnt + EXCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_exc_commit.sv
// Bench for wb_exc_commit: vector table, hand sequences for
// flush/drop/reset corners, random vectors vs a rule model.
module tb_wb_exc_commit;

  localparam logic [31:0] ENTRY = 32'hbfc00380;
  localparam int          EXW   = 8;
  localparam int          EXMAX = (1 << EXW) - 1;

  // exf bits: [6]if_adel [5]ri [4]ov [3]sys [2]bp [1]adel [0]ades
  typedef struct packed {
    logic [31:0] pc;
    logic        bd;
    logic [6:0]  exf;
    logic [31:0] badv;
    logic        eret;
    logic        mtc0;
    logic        mfc0;
    logic [7:0]  c0a;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] c0_rdata;
    logic [31:0] c0_epc;
    logic        has_int;
  } in_t;

  typedef struct packed {
    logic        ex;
    logic [4:0]  code;
    logic [31:0] badv;
    logic        rf_we;
    logic [31:0] rf_wdata;
    logic        mtc0_we;
    logic        eret_flush;
    logic        flush;
    logic [31:0] tgt;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  logic clk, reset, ms_to_ws_valid, ws_allowin;
  logic [31:0] ms_pc, ms_badvaddr, ms_result, c0_rdata, c0_epc;
  logic ms_bd, ms_ex_if_adel, ms_ex_ri, ms_ex_sys, ms_ex_bp;
  logic ms_ex_ov, ms_ex_adel, ms_ex_ades, ms_eret, ms_mtc0, ms_mfc0;
  logic [7:0] ms_c0_addr, c0_raddr;
  logic ms_gr_we, has_int, mtc0_we, wb_ex, wb_bd, eret_flush;
  logic rf_we, flush;
  logic [4:0] ms_dest, wb_excode, rf_waddr;
  logic [31:0] c0_wdata, wb_pc, wb_badvaddr, rf_wdata;
  logic [31:0] flush_target, retire_cnt;
  logic [EXW-1:0] ex_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int m_ret = 0;
  int m_exc = 0;

  wb_exc_commit #(.EX_ENTRY(ENTRY), .EXCNT_W(EXW)) dut (
    .clk(clk), .reset(reset),
    .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_bd(ms_bd),
    .ms_ex_if_adel(ms_ex_if_adel), .ms_ex_ri(ms_ex_ri),
    .ms_ex_sys(ms_ex_sys), .ms_ex_bp(ms_ex_bp),
    .ms_ex_ov(ms_ex_ov), .ms_ex_adel(ms_ex_adel),
    .ms_ex_ades(ms_ex_ades), .ms_badvaddr(ms_badvaddr),
    .ms_eret(ms_eret), .ms_mtc0(ms_mtc0), .ms_mfc0(ms_mfc0),
    .ms_c0_addr(ms_c0_addr), .ms_gr_we(ms_gr_we),
    .ms_dest(ms_dest), .ms_result(ms_result),
    .c0_rdata(c0_rdata), .c0_epc(c0_epc), .has_int(has_int),
    .mtc0_we(mtc0_we), .c0_raddr(c0_raddr), .c0_wdata(c0_wdata),
    .wb_ex(wb_ex), .wb_excode(wb_excode), .wb_bd(wb_bd),
    .wb_pc(wb_pc), .wb_badvaddr(wb_badvaddr),
    .eret_flush(eret_flush), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .flush(flush),
    .flush_target(flush_target), .retire_cnt(retire_cnt),
    .ex_cnt(ex_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic in_t ii(logic [31:0] pc, logic [6:0] exf,
                             logic hi, logic bd, logic gr_we,
                             logic [4:0] dest, logic [31:0] res);
    in_t v;
    v = '0;
    v.pc = pc; v.exf = exf; v.has_int = hi; v.bd = bd;
    v.gr_we = gr_we; v.dest = dest; v.result = res;
    return v;
  endfunction

  function automatic exp_t ee(logic ex, logic [4:0] code,
                              logic [31:0] badv, logic rwe,
                              logic [31:0] wd, logic mwe,
                              logic ef, logic fl, logic [31:0] tgt);
    exp_t e;
    e.ex = ex; e.code = code; e.badv = badv; e.rf_we = rwe;
    e.rf_wdata = wd; e.mtc0_we = mwe; e.eret_flush = ef;
    e.flush = fl; e.tgt = tgt;
    return e;
  endfunction

  // Reference: walk sources in priority order, first hit wins
  function automatic exp_t model(in_t v);
    exp_t e;
    logic [4:0] codes [8];
    logic       hits [8];
    int         first;
    codes = '{5'h00, 5'h04, 5'h0a, 5'h0c, 5'h08, 5'h09, 5'h04, 5'h05};
    hits  = '{v.has_int, v.exf[6], v.exf[5], v.exf[4],
              v.exf[3], v.exf[2], v.exf[1], v.exf[0]};
    first = -1;
    for (int k = 0; k < 8; k++)
      if (first < 0 && hits[k]) first = k;
    e.ex   = (first >= 0);
    e.code = e.ex ? codes[first] : 5'h00;
    e.badv = (first == 1) ? v.pc :
             (first == 6 || first == 7) ? v.badv : 32'h0;
    e.rf_we      = v.gr_we && !e.ex;
    e.rf_wdata   = v.mfc0 ? v.c0_rdata : v.result;
    e.mtc0_we    = v.mtc0 && !e.ex;
    e.eret_flush = v.eret && !e.ex;
    e.flush      = e.ex || e.eret_flush;
    e.tgt        = e.eret_flush ? v.c0_epc : ENTRY;
    return e;
  endfunction

  task automatic drive(in_t v, logic val);
    ms_to_ws_valid = val;
    ms_pc = v.pc; ms_bd = v.bd;
    ms_ex_if_adel = v.exf[6]; ms_ex_ri = v.exf[5];
    ms_ex_ov = v.exf[4]; ms_ex_sys = v.exf[3];
    ms_ex_bp = v.exf[2]; ms_ex_adel = v.exf[1];
    ms_ex_ades = v.exf[0]; ms_badvaddr = v.badv;
    ms_eret = v.eret; ms_mtc0 = v.mtc0; ms_mfc0 = v.mfc0;
    ms_c0_addr = v.c0a; ms_gr_we = v.gr_we; ms_dest = v.dest;
    ms_result = v.result; c0_rdata = v.c0_rdata;
    c0_epc = v.c0_epc; has_int = v.has_int;
  endtask

  task automatic compare(in_t v, exp_t e);
    chk("wb_ex", 32'(wb_ex), 32'(e.ex));
    chk("wb_excode", 32'(wb_excode), 32'(e.code));
    chk("wb_badvaddr", wb_badvaddr, e.badv);
    chk("wb_pc", wb_pc, v.pc);
    chk("wb_bd", 32'(wb_bd), 32'(v.bd));
    chk("rf_we", 32'(rf_we), 32'(e.rf_we));
    chk("rf_waddr", 32'(rf_waddr), 32'(v.dest));
    chk("rf_wdata", rf_wdata, e.rf_wdata);
    chk("mtc0_we", 32'(mtc0_we), 32'(e.mtc0_we));
    chk("c0_raddr", 32'(c0_raddr), 32'(v.c0a));
    chk("c0_wdata", c0_wdata, v.result);
    chk("eret_flush", 32'(eret_flush), 32'(e.eret_flush));
    chk("flush", 32'(flush), 32'(e.flush));
    chk("flush_target", flush_target, e.tgt);
  endtask

  task automatic post(logic ex);
    @(posedge clk);
    #1;
    if (!ex) m_ret++;
    else if (m_exc < EXMAX) m_exc++;
    chk("retire_cnt", retire_cnt, 32'(m_ret));
    chk("ex_cnt", 32'(ex_cnt), 32'(m_exc));
  endtask

  task automatic run_vec(in_t v, exp_t e);
    drive(v, 1'b1);
    @(posedge clk);
    #1 ms_to_ws_valid = 1'b0;
    @(negedge clk);
    compare(v, e);
    post(e.ex);
  endtask

  vec_t tbl[$];
  vec_t t;
  in_t  v, w;

  initial begin
    reset = 1'b1;
    drive('0, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_allowin", 32'(ws_allowin), 32'd1);
    chk("rst_wb_ex", 32'(wb_ex), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_target", flush_target, ENTRY);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_wb_pc", wb_pc, 32'd0);
    chk("rst_retire", retire_cnt, 32'd0);
    chk("rst_ex_cnt", 32'(ex_cnt), 32'd0);
    @(posedge clk);
    #1;

    t.i = ii(32'hbfc00000, 7'b0000000, 0, 0, 1, 5'd3, 32'd5);
    t.e = ee(0, 5'h00, 0, 1, 32'd5, 0, 0, 0, ENTRY);
    tbl.push_back(t);
    t.i = ii(32'hbfc00100, 7'b0000010, 0, 0, 1, 5'd4, 32'h1234);
    t.i.badv = 32'h80000003;
    t.e = ee(1, 5'h04, 32'h80000003, 0, 32'h1234, 0, 0, 1, ENTRY);
    tbl.push_back(t);
    t.i = ii(32'h00000002, 7'b1010000, 0, 0, 1, 5'd5, 32'd7);
    t.e = ee(1, 5'h04, 32'h2, 0, 32'd7, 0, 0, 1, ENTRY);
    tbl.push_back(t);
    t.i = ii(32'hbfc00010, 7'b0001000, 1, 1, 0, 5'd0, 32'd0);
    t.e = ee(1, 5'h00, 0, 0, 32'd0, 0, 0, 1, ENTRY);
    tbl.push_back(t);
    t.i = ii(32'hbfc00020, 7'b0000000, 0, 0, 0, 5'd0, 32'hff01);
    t.i.mtc0 = 1'b1; t.i.c0a = {5'd12, 3'd0};
    t.e = ee(0, 5'h00, 0, 0, 32'hff01, 1, 0, 0, ENTRY);
    tbl.push_back(t);
    t.i = ii(32'hbfc00024, 7'b0000000, 0, 0, 1, 5'd8, 32'd0);
    t.i.mfc0 = 1'b1; t.i.c0a = {5'd14, 3'd0};
    t.i.c0_rdata = 32'hdeadbeef;
    t.e = ee(0, 5'h00, 0, 1, 32'hdeadbeef, 0, 0, 0, ENTRY);
    tbl.push_back(t);
    t.i = ii(32'hbfc00028, 7'b0000000, 0, 0, 0, 5'd0, 32'd0);
    t.i.eret = 1'b1; t.i.c0_epc = 32'hbfc00200;
    t.e = ee(0, 5'h00, 0, 0, 32'd0, 0, 1, 1, 32'hbfc00200);
    tbl.push_back(t);
    t.i = ii(32'hbfc0002c, 7'b0100000, 0, 0, 0, 5'd0, 32'd0);
    t.i.eret = 1'b1; t.i.c0_epc = 32'hbfc00200;
    t.e = ee(1, 5'h0a, 0, 0, 32'd0, 0, 0, 1, ENTRY);
    tbl.push_back(t);
    t.i = ii(32'hbfc00030, 7'b0000001, 0, 0, 0, 5'd0, 32'd0);
    t.i.badv = 32'h00001001;
    t.e = ee(1, 5'h05, 32'h1001, 0, 32'd0, 0, 0, 1, ENTRY);
    tbl.push_back(t);
    t.i = ii(32'hbfc00034, 7'b0000101, 0, 0, 0, 5'd0, 32'd0);
    t.i.badv = 32'h00001001;
    t.e = ee(1, 5'h09, 0, 0, 32'd0, 0, 0, 1, ENTRY);
    tbl.push_back(t);
    t.i = ii(32'hbfc00038, 7'b0000000, 1, 0, 0, 5'd0, 32'h55);
    t.i.mtc0 = 1'b1;
    t.e = ee(1, 5'h00, 0, 0, 32'h55, 0, 0, 1, ENTRY);
    tbl.push_back(t);
    t.i = ii(32'hbfc0003c, 7'b0011000, 0, 0, 1, 5'd9, 32'd1);
    t.e = ee(1, 5'h0c, 0, 0, 32'd1, 0, 0, 1, ENTRY);
    tbl.push_back(t);
    t.i = ii(32'hbfc00040, 7'b0001100, 0, 0, 1, 5'd9, 32'd1);
    t.e = ee(1, 5'h08, 0, 0, 32'd1, 0, 0, 1, ENTRY);
    tbl.push_back(t);

    foreach (tbl[k]) run_vec(tbl[k].i, tbl[k].e);

    // data fault in WB while the next instruction is offered
    v = ii(32'hbfc00100, 7'b0000010, 0, 0, 1, 5'd4, 32'd0);
    v.badv = 32'h80000003;
    w = ii(32'hbfc00104, 7'b0000000, 0, 0, 1, 5'd9, 32'd99);
    drive(v, 1'b1);
    @(posedge clk);
    #1 drive(w, 1'b1);
    @(negedge clk);
    chk("drop_flush", 32'(flush), 32'd1);
    @(posedge clk);
    #1 ms_to_ws_valid = 1'b0;
    if (m_exc < EXMAX) m_exc++;
    @(negedge clk);
    chk("drop_rf_we", 32'(rf_we), 32'd0);
    chk("drop_flush_clr", 32'(flush), 32'd0);
    chk("drop_wb_pc", wb_pc, 32'hbfc00100);
    chk("drop_retire", retire_cnt, 32'(m_ret));
    chk("drop_ex_cnt", 32'(ex_cnt), 32'(m_exc));
    @(posedge clk);
    #1;

    // back-to-back retires with valid held high
    drive(ii(32'h100, 0, 0, 0, 1, 5'd1, 32'd11), 1'b1);
    @(posedge clk);
    #1 drive(ii(32'h104, 0, 0, 0, 1, 5'd2, 32'd22), 1'b1);
    @(negedge clk);
    chk("b2b_waddr1", 32'(rf_waddr), 32'd1);
    chk("b2b_we1", 32'(rf_we), 32'd1);
    @(posedge clk);
    #1 ms_to_ws_valid = 1'b0;
    m_ret++;
    @(negedge clk);
    chk("b2b_waddr2", 32'(rf_waddr), 32'd2);
    chk("b2b_wdata2", rf_wdata, 32'd22);
    chk("b2b_retire1", retire_cnt, 32'(m_ret));
    post(1'b0);

    for (int n = 0; n < 300; n++) begin
      v = '0;
      v.pc = $urandom;
      v.bd = 1'($urandom);
      for (int b = 0; b < 7; b++)
        v.exf[b] = ($urandom_range(0, 9) == 0);
      v.has_int  = ($urandom_range(0, 9) == 0);
      v.badv     = $urandom;
      v.eret     = ($urandom_range(0, 7) == 0);
      v.mtc0     = ($urandom_range(0, 7) == 0);
      v.mfc0     = ($urandom_range(0, 3) == 0);
      v.c0a      = 8'($urandom);
      v.gr_we    = 1'($urandom);
      v.dest     = 5'($urandom);
      v.result   = $urandom;
      v.c0_rdata = $urandom;
      v.c0_epc   = $urandom;
      run_vec(v, model(v));
    end

    // reset arriving while an exception is flushing
    drive(ii(32'h200, 7'b0100000, 0, 0, 0, 5'd0, 32'd0), 1'b1);
    @(posedge clk);
    #1 ms_to_ws_valid = 1'b0;
    @(negedge clk);
    chk("rf_flush_pre", 32'(flush), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    m_ret = 0;
    m_exc = 0;
    @(negedge clk);
    chk("rf_retire", retire_cnt, 32'd0);
    chk("rf_ex_cnt", 32'(ex_cnt), 32'd0);
    chk("rf_flush", 32'(flush), 32'd0);
    chk("rf_wb_pc", wb_pc, 32'd0);
    @(posedge clk);
    #1;

    v = ii(32'h300, 7'b0100000, 0, 0, 1, 5'd1, 32'd0);
    for (int n = 0; n < EXMAX; n++) run_vec(v, model(v));
    chk("ex_cnt_max", 32'(ex_cnt), 32'(EXMAX));
    run_vec(v, model(v));
    chk("ex_cnt_sat", 32'(ex_cnt), 32'(EXMAX));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
